// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared display timing and framebuffer geometry constants
package vga_pkg;

    // Display timing (pixel clock domain)
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int LINE     = 799;
    localparam int SCREEN   = 524;

    // Framebuffer geometry: one cell covers 4x4 screen pixels
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int PIX_W    = 8;
    localparam int OFS_W    = 15;
    localparam int FB_CELLS = FB_W * FB_H;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - game-logic write request handshake into the framebuffer
interface vram_arbiter_if;
    import vga_pkg::*;

    logic             wrReq;
    logic [OFS_W-1:0] wrAddr;
    logic [PIX_W-1:0] wrData;
    logic             wrAck;

    // Writer side: holds request/address/data until it sees wrAck
    modport master (
        output wrReq,
        output wrAddr,
        output wrData,
        input  wrAck
    );

    // Arbiter side: consumes the request and pulses wrAck
    modport slave (
        input  wrReq,
        input  wrAddr,
        input  wrData,
        output wrAck
    );

endinterface

// File: rtl/fb_addr_gen.sv
// rtl/fb_addr_gen.sv - screen position to framebuffer cell offset, shift-add only
module fb_addr_gen
    import vga_pkg::*;
(
    input  logic [9:0]       xPosition,
    input  logic [9:0]       yPosition,
    output logic [OFS_W-1:0] cellOffset
);

    logic [7:0]  cellX;
    logic [7:0]  cellY;
    logic [15:0] offsetSum;
    logic        unused_bits;

    // offset = (y/4)*160 + x/4, with *160 expanded to (y<<7)+(y<<5)
    always_comb begin
        cellX       = xPosition[9:2];
        cellY       = yPosition[9:2];
        offsetSum   = {1'b0, cellY, 7'b0} + {3'b0, cellY, 5'b0} + {8'b0, cellX};
        cellOffset  = offsetSum[OFS_W-1:0];
        unused_bits = ^{xPosition[1:0], yPosition[1:0], offsetSum[15]};
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port framebuffer arbiter with display priority and bank swap
module vram_arbiter
    import vga_pkg::*;
(
    input  logic             slowClk,
    input  logic             reset,
    input  logic [9:0]       xPosition,
    input  logic [9:0]       yPosition,
    input  logic             dataEnable,
    vram_arbiter_if.slave    wr,
    input  logic             swapReq,
    output logic             swapAck,
    output logic             frontBank,
    output logic [OFS_W:0]   memAddr,
    output logic             memWe,
    output logic [PIX_W-1:0] memWrData,
    input  logic [PIX_W-1:0] memRdData,
    output logic [PIX_W-1:0] pixelOut,
    output logic             pixelValid
);

    localparam logic [OFS_W-1:0] CELL_LIMIT = OFS_W'(FB_CELLS);
    localparam logic [9:0]       VBLANK_Y   = 10'(V_ACTIVE);

    logic [OFS_W-1:0] fetchOffset;
    logic [1:0]       fetchValid;

    logic             grant;
    logic             swapHit;
    logic [OFS_W:0]   nextAddr;
    logic             nextWe;
    logic [PIX_W-1:0] nextWrData;

    fb_addr_gen u_addr_gen (
        .xPosition  (xPosition),
        .yPosition  (yPosition),
        .cellOffset (fetchOffset)
    );

    // Port decision: display fetch first, then a write if the previous cycle was not an ack
    always_comb begin
        grant      = 1'b0;
        nextAddr   = memAddr;
        nextWe     = 1'b0;
        nextWrData = memWrData;
        swapHit    = swapReq && (xPosition == 10'd0) && (yPosition == VBLANK_Y);
        if (dataEnable) begin
            nextAddr = {frontBank, fetchOffset};
        end else if (wr.wrReq && !wr.wrAck) begin
            grant      = 1'b1;
            nextAddr   = {~frontBank, wr.wrAddr};
            nextWe     = (wr.wrAddr < CELL_LIMIT);
            nextWrData = wr.wrData;
        end
    end

    // Register the decision, the fetch-valid pipe, the returned pixel and the bank state
    always_ff @(posedge slowClk) begin
        if (reset) begin
            memAddr    <= '0;
            memWe      <= 1'b0;
            memWrData  <= '0;
            wr.wrAck   <= 1'b0;
            fetchValid <= 2'b00;
            pixelOut   <= '0;
            pixelValid <= 1'b0;
            frontBank  <= 1'b0;
            swapAck    <= 1'b0;
        end else begin
            memAddr    <= nextAddr;
            memWe      <= nextWe;
            memWrData  <= nextWrData;
            wr.wrAck   <= grant;
            fetchValid <= {fetchValid[0], dataEnable};
            pixelOut   <= fetchValid[1] ? memRdData : '0;
            pixelValid <= fetchValid[1];
            swapAck    <= swapHit;
            if (swapHit) begin
                frontBank <= ~frontBank;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;
    import vga_pkg::*;

    logic             slowClk = 1'b0;
    logic             reset;
    logic [9:0]       xPosition;
    logic [9:0]       yPosition;
    logic             dataEnable;
    logic             swapReq;
    logic             swapAck;
    logic             frontBank;
    logic [OFS_W:0]   memAddr;
    logic             memWe;
    logic [PIX_W-1:0] memWrData;
    logic [PIX_W-1:0] memRdData;
    logic [PIX_W-1:0] pixelOut;
    logic             pixelValid;
    logic             preload;

    logic [PIX_W-1:0] ram [0:65535];

    int checks   = 0;
    int failures = 0;

    vram_arbiter_if wr ();

    always #5 slowClk = ~slowClk;

    vram_arbiter dut (
        .slowClk    (slowClk),
        .reset      (reset),
        .xPosition  (xPosition),
        .yPosition  (yPosition),
        .dataEnable (dataEnable),
        .wr         (wr),
        .swapReq    (swapReq),
        .swapAck    (swapAck),
        .frontBank  (frontBank),
        .memAddr    (memAddr),
        .memWe      (memWe),
        .memWrData  (memWrData),
        .memRdData  (memRdData),
        .pixelOut   (pixelOut),
        .pixelValid (pixelValid)
    );

    // Synchronous single-port RAM, read data valid the cycle after the address
    always @(posedge slowClk) begin
        if (preload)
            ram[16'h0143] <= 8'h5A;
        else if (memWe)
            ram[memAddr] <= memWrData;
        memRdData <= ram[memAddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge slowClk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        preload    = 1'b1;
        wr.wrReq   = 1'b1;
        wr.wrAddr  = 15'd5;
        wr.wrData  = 8'h11;
        dataEnable = 1'b0;
        xPosition  = 10'd700;
        yPosition  = 10'd10;
        swapReq    = 1'b0;

        // Reset held 3 cycles with a pending write
        for (int i = 0; i < 3; i++) begin
            step();
            preload = 1'b0;
            check_eq("rst_bus", {13'd0, memAddr, memWe, memWrData, wr.wrAck}, 32'd0);
            check_eq("rst_misc", {20'd0, swapAck, frontBank, pixelOut, pixelValid}, 32'd0);
        end
        reset = 1'b0;
        step();
        check_eq("post_rst_ack", {wr.wrAck, memWe}, 2'b11);
        check_eq("post_rst_addr", memAddr, 16'h8005);
        check_eq("post_rst_data", memWrData, 8'h11);
        step();
        check_eq("post_rst_block", wr.wrAck, 1'b0);
        wr.wrReq = 1'b0;

        // Display fetch at x=13, y=9 -> cell 323
        dataEnable = 1'b1;
        xPosition  = 10'd13;
        yPosition  = 10'd9;
        step();
        check_eq("fetch_addr", memAddr, 16'h0143);
        check_eq("fetch_we", memWe, 1'b0);
        dataEnable = 1'b0;
        xPosition  = 10'd700;
        step();
        check_eq("fetch_early_valid", pixelValid, 1'b0);
        step();
        check_eq("fetch_pixel", pixelOut, 8'h5A);
        check_eq("fetch_valid", pixelValid, 1'b1);
        step();
        check_eq("fetch_after", {pixelValid, pixelOut}, 9'd0);

        // Write held across the active-to-blank edge
        yPosition  = 10'd20;
        wr.wrReq   = 1'b1;
        wr.wrAddr  = 15'd100;
        wr.wrData  = 8'h3C;
        dataEnable = 1'b1;
        for (int x = 636; x < 640; x++) begin
            xPosition = 10'(x);
            step();
            check_eq("contend_no_ack", wr.wrAck, 1'b0);
        end
        check_eq("contend_fetch_addr", memAddr, 16'h03BF);
        xPosition  = 10'd640;
        dataEnable = 1'b0;
        step();
        check_eq("contend_ack", {wr.wrAck, memWe}, 2'b11);
        check_eq("contend_addr", memAddr, 16'h8064);
        check_eq("contend_data", memWrData, 8'h3C);

        // Continuous requests in blanking: ack on alternate cycles
        for (int i = 0; i < 6; i++) begin
            xPosition = 10'(641 + i);
            step();
            check_eq("b2b_ack", wr.wrAck, (i % 2 == 1) ? 1'b1 : 1'b0);
        end
        wr.wrAddr = 15'd19200;
        step();
        check_eq("oor_block", wr.wrAck, 1'b0);
        step();
        check_eq("oor_ack", {wr.wrAck, memWe}, 2'b10);
        wr.wrReq = 1'b0;
        step();
        check_eq("oor_idle", wr.wrAck, 1'b0);

        // Swap requested from line 200, taken at x=0 / y=480
        swapReq   = 1'b1;
        yPosition = 10'd200;
        xPosition = 10'd700;
        step();
        check_eq("swap_wait", {swapAck, frontBank}, 2'b00);
        yPosition = 10'd479;
        xPosition = 10'd799;
        step();
        check_eq("swap_wait_edge", {swapAck, frontBank}, 2'b00);
        yPosition = 10'd480;
        xPosition = 10'd0;
        wr.wrReq  = 1'b1;
        wr.wrAddr = 15'd7;
        wr.wrData = 8'h77;
        step();
        check_eq("swap_ack", {swapAck, frontBank}, 2'b11);
        check_eq("swap_cycle_wr", {memAddr, memWe}, {16'h8007, 1'b1});
        xPosition = 10'd1;
        step();
        check_eq("swap_once", {swapAck, frontBank, wr.wrAck}, 3'b010);
        wr.wrReq  = 1'b0;
        xPosition = 10'd2;
        step();
        check_eq("swap_no_repeat", swapAck, 1'b0);
        swapReq = 1'b0;

        // After swap: fetch reads bank 1, writes go to bank 0
        dataEnable = 1'b1;
        yPosition  = 10'd0;
        xPosition  = 10'd400;
        step();
        check_eq("bank1_fetch_addr", memAddr, 16'h8064);
        dataEnable = 1'b0;
        xPosition  = 10'd700;
        step();
        step();
        check_eq("bank1_pixel", {pixelValid, pixelOut}, {1'b1, 8'h3C});
        wr.wrReq  = 1'b1;
        wr.wrAddr = 15'd9;
        wr.wrData = 8'h99;
        step();
        check_eq("bank0_write", {memAddr, memWe, wr.wrAck}, {16'h0009, 2'b11});
        wr.wrReq = 1'b0;
        step();

        // Reset asserted in the grant cycle
        wr.wrReq  = 1'b1;
        wr.wrAddr = 15'd3;
        reset     = 1'b1;
        step();
        check_eq("midrst_bus", {memWe, wr.wrAck, frontBank}, 3'b000);
        reset = 1'b0;
        step();
        check_eq("midrst_rereq", {memAddr, wr.wrAck}, {16'h8003, 1'b1});
        wr.wrReq = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
